// File: rtl/cobra_seg_display.sv
// Multiplexed 8-digit common-anode hex display for the Cobra OUT word; the word is committed only at frame boundaries.
// Optional build macro COBRA_SEG_BLANK_EN enables leading-zero blanking.
module cobra_seg_display #(
    parameter int CLK_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] VALUE,
    input  logic        FREEZE,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRES_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pres_reg;
    logic [2:0]    idx_reg;
    logic [31:0]   pend_reg;
    logic [31:0]   disp_reg;
    logic [7:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          frame_reg;

    logic          tick;
    logic [2:0]    idx_next;
    logic          load;
    logic [31:0]   disp_eff;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_next;

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The word shown after this edge: on an unfrozen wrap it is the pending word, not disp.
    always_comb begin
        tick     = (pres_reg == PRES_MAX);
        idx_next = idx_reg + 3'd1;
        load     = tick && (idx_next == 3'd0) && !FREEZE;
        disp_eff = load ? pend_reg : disp_reg;
        nibble   = disp_eff[{idx_next, 2'b00} +: 4];
    end

`ifdef COBRA_SEG_BLANK_EN
    logic [7:0] upper_zero;
    assign upper_zero[0] = 1'b0;
    for (genvar gi = 1; gi < 8; gi++) begin : g_upper_zero
        assign upper_zero[gi] = (disp_eff[31:4*gi] == '0);
    end
    assign blank = upper_zero[idx_next];
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? 7'h7F : hexseg(nibble);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pres_reg  <= '0;
            idx_reg   <= 3'd7;
            pend_reg  <= '0;
            disp_reg  <= '0;
            an_reg    <= 8'hFF;
            seg_reg   <= 7'h7F;
            frame_reg <= 1'b0;
        end else begin
            pend_reg  <= VALUE;
            pres_reg  <= tick ? '0 : pres_reg + PW'(1);
            frame_reg <= load;
            if (tick) begin
                idx_reg <= idx_next;
                an_reg  <= ~(8'b1 << idx_next);
                seg_reg <= seg_next;
                if (load) begin
                    disp_reg <= pend_reg;
                end
            end
        end
    end

    assign AN    = an_reg;
    assign SEG   = seg_reg;
    assign DP    = 1'b1;
    assign FRAME = frame_reg;

endmodule
